// File: rtl/capture_controller_if.sv
// -----------------------------------------------------------------------------
// capture_controller_if
//
// Bundles every non-clock/reset signal of the capture controller.
//   master : the surrounding system (sample source, edge detector, readout)
//   slave  : capture_controller itself
//
// Signals (direction seen from the slave):
//   start        in   one-clock arm pulse
//   pretrigger   in   samples kept before the trigger sample
//   input_sample in   ADC sample
//   input_rdy    in   sample valid
//   triggered    in   edge-detector pulse (refers to previous input_rdy)
//   rd_next      in   advance readout pointer
//   wr_en        out  RAM write strobe
//   wr_addr      out  RAM write address
//   wr_data      out  RAM write data
//   busy         out  capture in progress
//   done         out  buffer complete
//   trig_addr    out  address of trigger sample
//   start_addr   out  address of oldest sample
//   rd_addr      out  readout address
//   auto_trig    out  capture ended by timeout
// -----------------------------------------------------------------------------
interface capture_controller_if #(
    parameter int BITS_ADC   = 8,
    parameter int ADDR_WIDTH = 8
);
    logic                  start;
    logic [ADDR_WIDTH-1:0] pretrigger;
    logic [BITS_ADC-1:0]   input_sample;
    logic                  input_rdy;
    logic                  triggered;
    logic                  rd_next;
    logic                  wr_en;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [BITS_ADC-1:0]   wr_data;
    logic                  busy;
    logic                  done;
    logic [ADDR_WIDTH-1:0] trig_addr;
    logic [ADDR_WIDTH-1:0] start_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  auto_trig;

    modport master (
        output start, pretrigger, input_sample, input_rdy, triggered, rd_next,
        input  wr_en, wr_addr, wr_data, busy, done, trig_addr, start_addr,
               rd_addr, auto_trig
    );

    modport slave (
        input  start, pretrigger, input_sample, input_rdy, triggered, rd_next,
        output wr_en, wr_addr, wr_data, busy, done, trig_addr, start_addr,
               rd_addr, auto_trig
    );
endinterface

// File: rtl/capture_controller.sv
// -----------------------------------------------------------------------------
// capture_controller
//
// Sequences one acquisition into an external circular sample RAM: fills a
// programmable number of pre-trigger samples, waits for the edge detector's
// trigger pulse, completes the buffer with post-trigger samples, then exposes
// the oldest-sample address and a sequential read pointer for readout.
//
// Ports:
//   clk  clock
//   rst  asynchronous, active-low reset
//   bus  capture_controller_if.slave (control, sample stream, RAM write port,
//        readout pointer, status)
//
// Optional feature: define CAPTURE_AUTO_TRIGGER_EN to force a trigger after
// AUTO_TIMEOUT samples written while waiting for a trigger. Without the
// macro the block waits indefinitely and auto_trig stays 0.
// -----------------------------------------------------------------------------
module capture_controller #(
    parameter int BITS_ADC   = 8,
    parameter int ADDR_WIDTH = 8
`ifdef CAPTURE_AUTO_TRIGGER_EN
    ,
    parameter int AUTO_TIMEOUT = 1024
`endif
) (
    input  logic                 clk,
    input  logic                 rst,
    capture_controller_if.slave  bus
);

    typedef enum logic [2:0] {
        IDLE,
        PRE_FILL,
        WAIT_TRIG,
        POST_FILL,
        DONE
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] ONE = 1;

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_ptr;
    logic [ADDR_WIDTH-1:0] cnt;
    logic [ADDR_WIDTH-1:0] pre;
    logic                  armed;

    logic                  wr_en_q;
    logic [ADDR_WIDTH-1:0] wr_addr_q;
    logic [BITS_ADC-1:0]   wr_data_q;
    logic                  busy_q;
    logic                  done_q;
    logic [ADDR_WIDTH-1:0] trig_addr_q;
    logic [ADDR_WIDTH-1:0] start_addr_q;
    logic [ADDR_WIDTH-1:0] rd_addr_q;
    logic                  auto_trig_q;

    // Samples are stored only while a capture is actively filling.
    logic                  capture_write;
    // Post-trigger samples needed: DEPTH - pre - 1, which is ~pre in modular width.
    logic [ADDR_WIDTH-1:0] post_total;
    // Most recently written address: the sample the trigger pulse refers to.
    logic [ADDR_WIDTH-1:0] last_addr;
    logic [ADDR_WIDTH-1:0] trig_start;
    // A write concurrent with the trigger already counts as post sample #1.
    logic [ADDR_WIDTH-1:0] post_first;
    logic                  trig_hit;
    logic                  force_trig;
    logic                  accept;

    assign capture_write = bus.input_rdy &&
                           (state == PRE_FILL || state == WAIT_TRIG || state == POST_FILL);
    assign post_total    = ~pre;
    assign last_addr     = wr_ptr - ONE;
    assign trig_start    = last_addr - pre;
    assign post_first    = capture_write ? ONE : '0;
    // The trigger is only honoured once a sample has been written in
    // WAIT_TRIG, so at least pre samples always precede the trigger sample.
    assign trig_hit      = (state == WAIT_TRIG) && armed && bus.triggered;
    assign accept        = trig_hit || force_trig;

`ifdef CAPTURE_AUTO_TRIGGER_EN
    localparam int                TO_W     = $clog2(AUTO_TIMEOUT + 1);
    localparam logic [TO_W-1:0]   TO_LIMIT = TO_W'(AUTO_TIMEOUT);

    logic [TO_W-1:0] to_cnt;

    // A genuine trigger in the same clock takes precedence over the timeout.
    assign force_trig = (state == WAIT_TRIG) && !trig_hit && (to_cnt == TO_LIMIT);
`else
    assign force_trig = 1'b0;
`endif

    // NOTE: every register in this block, including the FSM state, is updated
    // with non-blocking assignments so all of them see pre-edge values.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= IDLE;
            wr_ptr       <= '0;
            cnt          <= '0;
            pre          <= '0;
            armed        <= 1'b0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            trig_addr_q  <= '0;
            start_addr_q <= '0;
            rd_addr_q    <= '0;
            auto_trig_q  <= 1'b0;
`ifdef CAPTURE_AUTO_TRIGGER_EN
            to_cnt       <= '0;
`endif
        end else begin
            // NOTE: default-low here turns wr_en into a one-clock strobe
            // without needing an explicit clear in every branch.
            wr_en_q <= 1'b0;

            if (bus.start) begin
                // Arming restarts from any state, aborting a capture in flight.
                wr_ptr      <= '0;
                cnt         <= '0;
                pre         <= bus.pretrigger;
                armed       <= 1'b0;
                done_q      <= 1'b0;
                auto_trig_q <= 1'b0;
                busy_q      <= 1'b1;
                state       <= (bus.pretrigger == '0) ? WAIT_TRIG : PRE_FILL;
`ifdef CAPTURE_AUTO_TRIGGER_EN
                to_cnt      <= '0;
`endif
            end else begin
                if (capture_write) begin
                    wr_en_q   <= 1'b1;
                    wr_addr_q <= wr_ptr;
                    wr_data_q <= bus.input_sample;
                    wr_ptr    <= wr_ptr + ONE;
                end

                case (state)
                    PRE_FILL: begin
                        if (capture_write) begin
                            if (cnt + ONE == pre) begin
                                state <= WAIT_TRIG;
                                cnt   <= '0;
                            end else begin
                                cnt <= cnt + ONE;
                            end
                        end
                    end

                    WAIT_TRIG: begin
                        if (accept) begin
                            trig_addr_q  <= last_addr;
                            start_addr_q <= trig_start;
                            auto_trig_q  <= force_trig;
                            cnt          <= post_first;
                            // pre == DEPTH-1 needs no post samples at all.
                            if (post_total == '0 || post_first == post_total) begin
                                state     <= DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                rd_addr_q <= trig_start;
                            end else begin
                                state <= POST_FILL;
                            end
                        end else if (capture_write) begin
                            armed <= 1'b1;
`ifdef CAPTURE_AUTO_TRIGGER_EN
                            to_cnt <= to_cnt + 1'b1;
`endif
                        end
                    end

                    POST_FILL: begin
                        if (capture_write) begin
                            cnt <= cnt + ONE;
                            if (cnt + ONE == post_total) begin
                                state     <= DONE;
                                busy_q    <= 1'b0;
                                done_q    <= 1'b1;
                                rd_addr_q <= start_addr_q;
                            end
                        end
                    end

                    DONE: begin
                        // Readout pointer is free-running; it simply wraps.
                        if (bus.rd_next) begin
                            rd_addr_q <= rd_addr_q + ONE;
                        end
                    end

                    default: ;
                endcase
            end
        end
    end

    assign bus.wr_en      = wr_en_q;
    assign bus.wr_addr    = wr_addr_q;
    assign bus.wr_data    = wr_data_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.trig_addr  = trig_addr_q;
    assign bus.start_addr = start_addr_q;
    assign bus.rd_addr    = rd_addr_q;
    assign bus.auto_trig  = auto_trig_q;

endmodule

// File: doc/capture_controller.md
# capture_controller

Sequences one acquisition into a circular sample RAM and sits directly downstream of the edge detector. It stores a programmable number of pre-trigger samples and waits for the detector's `triggered` pulse. It then completes the buffer with post-trigger samples and exposes the oldest-sample address and a sequential read pointer for readout. The RAM itself is external; this block drives its write port and read address.

## Interface
- `BITS_ADC`, 8, sample width
- `ADDR_WIDTH`, 8, RAM address width; DEPTH = 2**ADDR_WIDTH
- `AUTO_TIMEOUT`, 1024, samples in WAIT_TRIG before forced trigger (only with macro)

- `clk`  in  1  clock
- `rst`  in  1  reset, asynchronous, active-low
- `start`  in  1  one-clock arm pulse
- `pretrigger`  in  ADDR_WIDTH  samples kept before trigger sample, sampled on `start`
- `input_sample`  in  BITS_ADC  sample, same stream fed to edge detector
- `input_rdy`  in  1  sample valid
- `triggered`  in  1  edge detector pulse, refers to sample of previous `input_rdy`
- `rd_next`  in  1  advance read pointer
- `wr_en`  out  1  RAM write strobe
- `wr_addr`  out  ADDR_WIDTH  RAM write address
- `wr_data`  out  BITS_ADC  RAM write data
- `busy`  out  1  capture in progress
- `done`  out  1  buffer complete, readable
- `trig_addr`  out  ADDR_WIDTH  address of trigger sample
- `start_addr`  out  ADDR_WIDTH  address of oldest sample = trig_addr − pre (mod DEPTH)
- `rd_addr`  out  ADDR_WIDTH  readout address
- `auto_trig`  out  1  capture ended by timeout

## Operation
- States: IDLE, PRE_FILL, WAIT_TRIG, POST_FILL, DONE.
- `start` in any state: wr_ptr←0, cnt←0, pre←pretrigger, done←0, auto_trig←0, busy←1. Next state is PRE_FILL, or WAIT_TRIG if pre==0. A mid-capture `start` aborts and restarts.
- Every `input_rdy` outside IDLE/DONE writes: wr_addr←wr_ptr, wr_data←input_sample, wr_en←1 for one clock, wr_ptr←wr_ptr+1 (wraps mod DEPTH).
- PRE_FILL: count writes; on pre-th write → WAIT_TRIG. `triggered` ignored.
- WAIT_TRIG: `armed` flag set on first write in this state. `triggered` is ignored until `armed`=1. This guarantees ≥pre samples precede the trigger sample.
- On `triggered`=1 with `armed`: trig_addr←wr_ptr−1 (mod DEPTH), cnt←0, → POST_FILL. If DEPTH−pre−1==0 → DONE directly.
- Simultaneous `triggered` and `input_rdy` in WAIT_TRIG: the trigger takes effect, and the concurrent write counts as post sample #1.
- POST_FILL: count writes; on write number DEPTH−pre−1 → DONE. Buffer then holds pre samples, the trigger sample and DEPTH−pre−1 later samples; total DEPTH.
- DONE: busy←0, done←1, rd_addr←start_addr. Each `rd_next` advances rd_addr+1 (wraps). No writes occur. Pointer is unbounded, and wrapping past DEPTH reads repeat.
- IDLE and DONE ignore `input_rdy`, `triggered` and (in IDLE) `rd_next`.

## Timing
- Reset (rst=0, async): state IDLE. wr_en, wr_addr, wr_data, busy, done, trig_addr, start_addr, rd_addr and auto_trig are all 0.
- All outputs are registered. wr_en/wr_addr/wr_data appear 1 clock after `input_rdy`.
- State changes 1 clock after the causing `start`/`input_rdy`/`triggered` edge.
- done rises on the clock after the last post write is issued. rd_addr is valid the same clock.
- `triggered` latency matches the detector's one-clock delay. wr_ptr−1 at that clock is exactly the crossing sample.
- The block accepts back-to-back `input_rdy` every clock.

## Configuration
- `CAPTURE_AUTO_TRIGGER_EN` defined: WAIT_TRIG counts writes. After AUTO_TIMEOUT writes with no accepted trigger, the block forces a trigger on the last written sample (trig_addr←wr_ptr−1) and sets auto_trig←1. POST_FILL and DONE then proceed normally. A real `triggered` in the same clock wins, and auto_trig stays 0.
- Undefined: no timeout counter; WAIT_TRIG waits indefinitely; auto_trig tied 0.

## Test plan
- ADDR_WIDTH=4, pretrigger=5, samples 0,1,2… every clock, `triggered` pulse after sample 9's `input_rdy` -> trig_addr=9, start_addr=4, done after sample 19 written, 16 rd_next give addresses 4..15,0..3.
- pretrigger=0, trigger on first WAIT_TRIG sample -> trig_addr=0, start_addr=0, 15 post writes, done.
- `triggered` arriving during PRE_FILL and on the clock immediately after the PRE_FILL→WAIT_TRIG transition (before any WAIT_TRIG write) -> ignored, state stays WAIT_TRIG.
- Trigger after long wait with wr_ptr wrapped (20 WAIT_TRIG samples, pre=5) -> trig_addr=(5+20−1) mod 16=8, start_addr=3.
- rst low mid-POST_FILL, and `start` mid-WAIT_TRIG -> all outputs 0 immediately / restart from wr_addr 0 with done=0.
- With CAPTURE_AUTO_TRIGGER_EN, AUTO_TIMEOUT=8, no trigger -> forced trigger after 8th WAIT_TRIG write, auto_trig=1, done after remaining post samples.
